iq_stream_source: RTL and testbench

Buffered I/Q sample transmitter that drives the AXI-stream style input handshake consumed by the arg-max and CAF blocks. Software or upstream logic loads up to `buffer_length` signed I/Q pairs into an internal RAM, then pulses `start`. The block replays `num_samples` pairs in address order as a valid/ready stream with a `tlast` marker. It replaces the file-driven stimulus path with a synthesizable source.

---
 rtl/iq_stream_source_if.sv | 10 +
 rtl/iq_stream_source.sv | 117 +++++++++++
 tb/tb_iq_stream_source.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/iq_stream_source_if.sv
// iq_stream_source_if: valid/ready I/Q beat channel between the sample source and its consumer
interface iq_stream_source_if #(parameter int i_bits = 12, parameter int q_bits = 12);
  logic [i_bits-1:0] xi;
  logic [q_bits-1:0] xq;
  logic m_axis_tvalid;
  logic m_axis_tlast;
  logic s_axis_tready;
  modport master (output xi, xq, m_axis_tvalid, m_axis_tlast, input s_axis_tready);
  modport slave (input xi, xq, m_axis_tvalid, m_axis_tlast, output s_axis_tready);
endinterface

// File: rtl/iq_stream_source.sv
// iq_stream_source: RAM-buffered I/Q pair replay as a valid/ready stream with tlast and done
module iq_stream_source #(
  parameter int i_bits = 12,
  parameter int q_bits = 12,
  parameter int buffer_length = 64,
  parameter int index_bits = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [index_bits-1:0] wr_addr,
  input  logic [i_bits-1:0]     wr_xi,
  input  logic [q_bits-1:0]     wr_xq,
  input  logic                  start,
  input  logic [index_bits:0]   num_samples,
  output logic                  busy,
  output logic                  done,
  iq_stream_source_if.master    axis
);
  localparam int dw = i_bits + q_bits;
  localparam logic [index_bits:0] max_n = (index_bits+1)'(buffer_length);
  localparam logic [index_bits:0] one = (index_bits+1)'(1);
  typedef enum logic [1:0] {IDLE, PRIME, STREAM, DONE} state_t;
  state_t state_q, state_d;
  logic [index_bits:0] n_q, n_d, ptr_q, ptr_d, beat_q, beat_d;
  logic [dw-1:0] mem [buffer_length];
  logic [dw-1:0] rdata_q, data_q, data_d, skid_q, skid_d;
  logic valid_q, valid_d, last_q, last_d, skid_v_q, skid_v_d, rdv_q, rdv_d;
  logic rd_en, xfer, issue;
  logic [index_bits-1:0] rd_addr;
  logic [1:0] occ;
  assign xfer = valid_q & axis.s_axis_tready;
  assign occ = 2'(valid_q) + 2'(skid_v_q) + 2'(rdv_q) - 2'(xfer);
  assign issue = ptr_q < n_q && occ <= 2'd1;
  assign rd_addr = state_q == IDLE ? '0 : ptr_q[index_bits-1:0];
  assign axis.m_axis_tvalid = valid_q;
  assign axis.m_axis_tlast = last_q;
  assign axis.xi = data_q[dw-1:q_bits];
  assign axis.xq = data_q[q_bits-1:0];
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  always_ff @(posedge clk) begin
    if (wr_en && state_q == IDLE) mem[wr_addr] <= {wr_xi, wr_xq};
    if (rd_en) rdata_q <= mem[rd_addr];
  end
  always_comb begin
    state_d = state_q;
    n_d = n_q;
    ptr_d = ptr_q;
    beat_d = beat_q;
    valid_d = valid_q;
    last_d = last_q;
    data_d = data_q;
    skid_d = skid_q;
    skid_v_d = skid_v_q;
    rdv_d = 1'b0;
    rd_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && num_samples != '0) begin
          n_d = num_samples > max_n ? max_n : num_samples;
          ptr_d = one;
          beat_d = '0;
          rd_en = 1'b1;
          rdv_d = 1'b1;
          state_d = PRIME;
        end
      end
      PRIME: begin
        rdv_d = 1'b1;
        state_d = STREAM;
      end
      STREAM: begin
        beat_d = beat_q + (index_bits+1)'(xfer);
        skid_d = rdv_q ? rdata_q : skid_q;
        if (!valid_q || xfer) begin
          valid_d = skid_v_q | rdv_q;
          data_d = skid_v_q ? skid_q : rdv_q ? rdata_q : '0;
          last_d = (skid_v_q | rdv_q) && beat_d == n_q - one;
          skid_v_d = skid_v_q & rdv_q;
        end else begin
          skid_v_d = skid_v_q | rdv_q;
        end
        rd_en = issue;
        rdv_d = issue;
        ptr_d = ptr_q + (index_bits+1)'(issue);
        state_d = xfer && last_q ? DONE : STREAM;
      end
      DONE: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      n_q <= '0;
      ptr_q <= '0;
      beat_q <= '0;
      valid_q <= 1'b0;
      last_q <= 1'b0;
      data_q <= '0;
      skid_q <= '0;
      skid_v_q <= 1'b0;
      rdv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      ptr_q <= ptr_d;
      beat_q <= beat_d;
      valid_q <= valid_d;
      last_q <= last_d;
      data_q <= data_d;
      skid_q <= skid_d;
      skid_v_q <= skid_v_d;
      rdv_q <= rdv_d;
    end
  end
endmodule

// File: tb/tb_iq_stream_source.sv
// tb_iq_stream_source: scoreboard bench replaying a modelled sample RAM against the stream source
module tb_iq_stream_source;
  logic clk = 1'b0, reset = 1'b1, wr_en = 1'b0, start = 1'b0;
  logic [5:0] wr_addr = '0;
  logic [11:0] wr_xi = '0, wr_xq = '0;
  logic [6:0] num_samples = '0;
  logic busy, done;
  iq_stream_source_if #(.i_bits(12), .q_bits(12)) axis();
  iq_stream_source #(.i_bits(12), .q_bits(12), .buffer_length(64), .index_bits(6)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_xi(wr_xi), .wr_xq(wr_xq),
    .start(start), .num_samples(num_samples), .busy(busy), .done(done), .axis(axis)
  );
  always #5 clk = ~clk;
  typedef struct {int i; int q; bit last;} beat_t;
  beat_t exp_q[$];
  int tests = 0, fails = 0, beats_seen = 0, mode = 0, pidx = 0;
  int mi[64], mq[64];
  bit pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  bit exp_done = 1'b0, held = 1'b0;
  int hi, hq, hl;
  always @(posedge clk) begin
    #1;
    axis.s_axis_tready = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) : mode == 2 ? pat[pidx % 6] : 1'b0;
    if (mode == 2) pidx++;
  end
  always @(negedge clk) begin
    if (reset) begin
      exp_done = 1'b0;
      held = 1'b0;
    end else begin
      if (exp_done || done) begin
        tests++;
        if (done !== exp_done) begin
          fails++;
          $display("FAIL done_pulse: got %0d required %0d", done, exp_done);
        end
      end
      exp_done = 1'b0;
      if (held) begin
        tests++;
        if (axis.m_axis_tvalid !== 1'b1 || $signed(axis.xi) != hi || $signed(axis.xq) != hq || int'(axis.m_axis_tlast) != hl) begin
          fails++;
          $display("FAIL stall_hold: got valid=%0d (%0d,%0d,last=%0d) required valid=1 (%0d,%0d,last=%0d)",
                   axis.m_axis_tvalid, $signed(axis.xi), $signed(axis.xq), axis.m_axis_tlast, hi, hq, hl);
        end
      end
      held = 1'b0;
      if (axis.m_axis_tvalid && axis.s_axis_tready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL beat: got unexpected (%0d,%0d,last=%0d) required no beat", $signed(axis.xi), $signed(axis.xq), axis.m_axis_tlast);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          if ($signed(axis.xi) != e.i || $signed(axis.xq) != e.q || axis.m_axis_tlast !== e.last) begin
            fails++;
            $display("FAIL beat: got (%0d,%0d,last=%0d) required (%0d,%0d,last=%0d)",
                     $signed(axis.xi), $signed(axis.xq), axis.m_axis_tlast, e.i, e.q, e.last);
          end
          exp_done = e.last;
          beats_seen++;
        end
      end else if (axis.m_axis_tvalid) begin
        held = 1'b1;
        hi = $signed(axis.xi);
        hq = $signed(axis.xq);
        hl = int'(axis.m_axis_tlast);
      end
    end
  end
  task automatic chk(input string nm, input int got, input int req);
    tests++;
    if (got != req) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", nm, got, req);
    end
  endtask
  task automatic wr(input int a, input int i, input int q);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = 6'(a); wr_xi = 12'(i); wr_xq = 12'(q);
    mi[a] = i; mq[a] = q;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask
  task automatic launch(input int n, input bit dow, input int a, input int i, input int q);
    int nn;
    @(posedge clk); #1;
    start = 1'b1; num_samples = 7'(n);
    if (dow) begin wr_en = 1'b1; wr_addr = 6'(a); wr_xi = 12'(i); wr_xq = 12'(q); end
    nn = n > 64 ? 64 : n;
    if (dow && a != 0) begin mi[a] = i; mq[a] = q; end
    for (int k = 0; k < nn; k++) exp_q.push_back('{mi[k], mq[k], k == nn - 1});
    if (dow) begin mi[a] = i; mq[a] = q; end
    @(posedge clk); #1;
    start = 1'b0; wr_en = 1'b0;
  endtask
  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || busy) && k < 3000) begin @(negedge clk); k++; end
    if (k >= 3000) begin
      tests++; fails++;
      $display("FAIL wait_idle: got timeout with %0d beats pending required idle", exp_q.size());
      exp_q.delete();
    end
  endtask
  task automatic chk_quiet(input string nm);
    chk({nm, "_xi"}, int'(axis.xi), 0);
    chk({nm, "_xq"}, int'(axis.xq), 0);
    chk({nm, "_valid"}, int'(axis.m_axis_tvalid), 0);
    chk({nm, "_last"}, int'(axis.m_axis_tlast), 0);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_done"}, int'(done), 0);
  endtask
  initial begin
    int k;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_quiet("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    for (int a = 0; a < 64; a++) begin
      if (a < 8) wr(a, a, -a);
      else wr(a, int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048);
    end
    launch(8, 1'b0, 0, 0, 0);
    @(negedge clk);
    chk("lat_busy", int'(busy), 1);
    chk("lat_valid1", int'(axis.m_axis_tvalid), 0);
    @(negedge clk);
    chk("lat_valid2", int'(axis.m_axis_tvalid), 0);
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      chk("full_rate_valid", int'(axis.m_axis_tvalid), 1);
    end
    @(negedge clk);
    chk("full_rate_end_valid", int'(axis.m_axis_tvalid), 0);
    chk("full_rate_done", int'(done), 1);
    wait_idle();
    mode = 2; pidx = 0;
    launch(8, 1'b0, 0, 0, 0);
    wait_idle();
    mode = 0;
    launch(0, 1'b0, 0, 0, 0);
    repeat (3) begin
      @(negedge clk);
      chk("n0_busy", int'(busy), 0);
      chk("n0_valid", int'(axis.m_axis_tvalid), 0);
    end
    launch(100, 1'b0, 0, 0, 0);
    wait_idle();
    beats_seen = 0;
    launch(8, 1'b0, 0, 0, 0);
    k = 0;
    while (beats_seen < 4 && k < 50) begin @(posedge clk); #1; k++; end
    chk("reset_mid_reached", int'(beats_seen >= 4), 1);
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk_quiet("reset_mid");
    launch(2, 1'b0, 0, 0, 0);
    wait_idle();
    mode = 1;
    launch(8, 1'b0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("busy_mid", int'(busy), 1);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = 6'd0; wr_xi = 12'd99; wr_xq = 12'd0; start = 1'b1; num_samples = 7'd3;
    @(posedge clk); #1;
    wr_en = 1'b0; start = 1'b0;
    wait_idle();
    launch(2, 1'b0, 0, 0, 0);
    wait_idle();
    launch(8, 1'b1, 0, 55, -55);
    wait_idle();
    launch(8, 1'b1, 3, 77, -77);
    wait_idle();
    launch(4, 1'b0, 0, 0, 0);
    wait_idle();
    mode = 3;
    launch(8, 1'b0, 0, 0, 0);
    k = 0;
    do begin @(negedge clk); k++; end while (!axis.m_axis_tvalid && k < 10);
    chk("hold_first_valid", int'(axis.m_axis_tvalid), 1);
    repeat (19) begin
      @(negedge clk);
      chk("hold_valid", int'(axis.m_axis_tvalid), 1);
    end
    mode = 0;
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      chk("release_valid", int'(axis.m_axis_tvalid), 1);
    end
    @(negedge clk);
    chk("release_done", int'(done), 1);
    wait_idle();
    repeat (6) begin
      mode = 1;
      repeat (4) wr(int'($urandom_range(0, 63)), int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048);
      launch(int'($urandom_range(1, 80)), 1'b0, 0, 0, 0);
      wait_idle();
    end
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
